// File: rtl/btn_event_gen.sv
// Turns a debounced button level into press/release/long/repeat strobes.
// Optional auto-repeat is built when BTN_AUTO_REPEAT_EN is defined.
module btn_event_gen #(
  parameter int LONG_MS   = 1000,
  parameter int REPEAT_MS = 200,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_1ms,
  input  logic             btn_level,
  output logic             press_pulse,
  output logic             release_pulse,
  output logic             long_pulse,
  output logic             repeat_pulse,
  output logic             held,
  output logic [CNT_W-1:0] hold_ms
);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    LONG_HELD
  } state_t;

  localparam logic [CNT_W-1:0] LONG_C = CNT_W'(LONG_MS);

  state_t           state_q, state_d;
  logic             s1_q, s2_q;
  logic [CNT_W-1:0] hold_q, hold_d, hold_inc;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic             long_q, long_d;
  logic             hold_sat;

`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_C = CNT_W'(REPEAT_MS);

  logic [CNT_W-1:0] rcnt_q, rcnt_d, rcnt_inc;
  logic             rep_q, rep_d;

  assign rcnt_inc     = rcnt_q + 1'b1;
  assign repeat_pulse = rep_q;
`else
  assign repeat_pulse = 1'b0;
`endif

  assign hold_inc = hold_q + 1'b1;
  assign hold_sat = &hold_q;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    long_d  = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
    rep_d   = 1'b0;
    rcnt_d  = rcnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (s2_q) begin
          state_d = PRESSED;
          press_d = 1'b1;
          hold_d  = '0;
        end
      end
      PRESSED: begin
        // Release outranks a tick landing in the same cycle
        if (!s2_q) begin
          state_d = IDLE;
          rel_d   = 1'b1;
          hold_d  = '0;
        end else if (tick_1ms) begin
          hold_d = hold_inc;
          if (hold_inc == LONG_C) begin
            state_d = LONG_HELD;
            long_d  = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
            rcnt_d  = '0;
`endif
          end
        end
      end
      LONG_HELD: begin
        if (!s2_q) begin
          state_d = IDLE;
          rel_d   = 1'b1;
          hold_d  = '0;
`ifdef BTN_AUTO_REPEAT_EN
          rcnt_d  = '0;
`endif
        end else if (tick_1ms) begin
          if (!hold_sat) hold_d = hold_inc;
`ifdef BTN_AUTO_REPEAT_EN
          if (rcnt_inc == REP_C) begin
            rep_d  = 1'b1;
            rcnt_d = '0;
          end else begin
            rcnt_d = rcnt_inc;
          end
`endif
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= IDLE;
      hold_q  <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      s1_q    <= btn_level;
      s2_q    <= s1_q;
      state_q <= state_d;
      hold_q  <= hold_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
    end
  end

`ifdef BTN_AUTO_REPEAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcnt_q <= '0;
      rep_q  <= 1'b0;
    end else begin
      rcnt_q <= rcnt_d;
      rep_q  <= rep_d;
    end
  end
`endif

  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign long_pulse    = long_q;
  assign held          = s2_q;
  assign hold_ms       = hold_q;

endmodule

// File: tb/tb_btn_event_gen.sv
// Randomised and directed bench for btn_event_gen against a
// tick-count reference model of the button events.
module tb_btn_event_gen;

  localparam int LONG = 10;
  localparam int REP  = 3;
  localparam int W    = 5;
  localparam int MAXV = (1 << W) - 1;
`ifdef BTN_AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         tick_1ms = 1'b0;
  logic         btn_level = 1'b0;
  logic         press_pulse, release_pulse;
  logic         long_pulse, repeat_pulse, held;
  logic [W-1:0] hold_ms;
  logic [W+4:0] dut_v;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  bit m_s1, m_s2, m_on;
  bit m_press, m_rel, m_long, m_rep;
  int m_cnt;

  always #5 clk = ~clk;

  btn_event_gen #(
    .LONG_MS  (LONG),
    .REPEAT_MS(REP),
    .CNT_W    (W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tick_1ms     (tick_1ms),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .held         (held),
    .hold_ms      (hold_ms)
  );

  assign dut_v = {press_pulse, release_pulse, long_pulse,
                  repeat_pulse, held, hold_ms};

  function automatic logic [W+4:0] mvec();
    logic [W-1:0] h;
    h = (m_cnt > MAXV) ? W'(MAXV) : W'(m_cnt);
    return {m_press, m_rel, m_long, m_rep, m_s2, h};
  endfunction

  task automatic mreset();
    m_s1 = 0; m_s2 = 0; m_on = 0; m_cnt = 0;
    m_press = 0; m_rel = 0; m_long = 0; m_rep = 0;
  endtask

  // Events by rule: count ticks since press, long at LONG,
  // repeat at every REP ticks beyond LONG, release wins.
  task automatic medge(input bit b, input bit t);
    bit rise, fall;
    rise = m_s2 && !m_on;
    fall = !m_s2 && m_on;
    m_press = rise; m_rel = fall;
    m_long = 0; m_rep = 0;
    if (rise) begin
      m_on = 1; m_cnt = 0;
    end else if (fall) begin
      m_on = 0; m_cnt = 0;
    end else if (m_on && t) begin
      m_cnt++;
      m_long = (m_cnt == LONG);
      m_rep = AR && (m_cnt > LONG) && ((m_cnt - LONG) % REP == 0);
    end
    m_s2 = m_s1;
    m_s1 = b;
  endtask

  task automatic step(input bit b, input bit t);
    btn_level = b;
    tick_1ms  = t;
    @(posedge clk);
    if (rst) mreset();
    else medge(b, t);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; btn_level = 1'b1;
    mreset();
    #3;
    n_vec++;
    if (dut_v !== '0) begin
      n_err++;
      $display("FAIL reset_init got %b exp 0", dut_v);
    end
    step(1, 0);
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step(1, 0);
      n_vec++;
      if (press_pulse !== (i == 3)) begin
        n_err++;
        $display("FAIL reset_press cyc%0d got %b exp %b",
                 i, press_pulse, (i == 3));
      end
      n_vec++;
      if (dut_v !== mvec()) begin
        n_err++;
        $display("FAIL reset_vec cyc%0d got %b exp %b", i, dut_v, mvec());
      end
    end
    for (int i = 0; i < 4; i++) step(0, 0);
  endtask

  task automatic test_short_press();
    int np, nr, nl;
    np = 0; nr = 0; nl = 0;
    for (int i = 0; i < 20; i++) begin
      step(i < 10, (i >= 3) && (i < 8));
      np += press_pulse; nr += release_pulse; nl += long_pulse;
      n_vec++;
      if (dut_v !== mvec()) begin
        n_err++;
        $display("FAIL short_vec cyc%0d got %b exp %b", i, dut_v, mvec());
      end
    end
    n_vec++;
    if ({np, nr, nl} !== {32'd1, 32'd1, 32'd0}) begin
      n_err++;
      $display("FAIL short_counts got p%0d r%0d l%0d exp p1 r1 l0",
               np, nr, nl);
    end
  endtask

  task automatic test_long_press();
    int nl, nrep, tk, ltick;
    int rticks[$];
    nl = 0; nrep = 0; tk = 0; ltick = 0;
    for (int i = 0; i < 3; i++) step(1, 0);
    for (int i = 0; i < 20; i++) begin
      step(1, 1);
      tk++;
      if (long_pulse) begin nl++; ltick = tk; end
      if (repeat_pulse) begin nrep++; rticks.push_back(tk); end
      n_vec++;
      if (dut_v !== mvec()) begin
        n_err++;
        $display("FAIL long_vec tick%0d got %b exp %b", tk, dut_v, mvec());
      end
    end
    n_vec++;
    if (nl != 1 || ltick != 10) begin
      n_err++;
      $display("FAIL long_tick got n%0d at %0d exp n1 at 10", nl, ltick);
    end
    n_vec++;
    if (nrep != (AR ? 3 : 0) ||
        (AR && !(rticks[0] == 13 && rticks[1] == 16 && rticks[2] == 19))) begin
      n_err++;
      $display("FAIL repeat_ticks got n%0d exp n%0d", nrep, AR ? 3 : 0);
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 0);
      n_vec++;
      if (dut_v !== mvec()) begin
        n_err++;
        $display("FAIL long_rel cyc%0d got %b exp %b", i, dut_v, mvec());
      end
    end
  endtask

  task automatic test_collision();
    for (int i = 0; i < 4; i++) step(1, 0);
    for (int i = 0; i < 9; i++) step(1, 1);
    step(0, 0);
    step(0, 0);
    step(0, 1);
    n_vec++;
    if ({release_pulse, long_pulse, hold_ms} !== {1'b1, 1'b0, W'(0)}) begin
      n_err++;
      $display("FAIL collision got r%b l%b h%0d exp r1 l0 h0",
               release_pulse, long_pulse, hold_ms);
    end
    n_vec++;
    if (dut_v !== mvec()) begin
      n_err++;
      $display("FAIL collision_vec got %b exp %b", dut_v, mvec());
    end
    for (int i = 0; i < 3; i++) step(0, 0);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 3; i++) step(1, 0);
    for (int i = 0; i < 45; i++) begin
      step(1, 1);
      n_vec++;
      if (dut_v !== mvec()) begin
        n_err++;
        $display("FAIL sat_vec tick%0d got %b exp %b", i, dut_v, mvec());
      end
    end
    n_vec++;
    if (hold_ms !== W'(MAXV)) begin
      n_err++;
      $display("FAIL sat_hold got %0d exp %0d", hold_ms, MAXV);
    end
    for (int i = 0; i < 3; i++) step(0, 0);
    n_vec++;
    if (hold_ms !== '0 || release_pulse !== 1'b1) begin
      n_err++;
      $display("FAIL sat_clear got h%0d r%b exp h0 r1",
               hold_ms, release_pulse);
    end
    step(0, 0);
  endtask

  task automatic test_back_to_back();
    bit pat[$] = '{1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0};
    int np, nr;
    np = 0; nr = 0;
    foreach (pat[i]) begin
      step(pat[i], 1'(i % 2));
      np += press_pulse; nr += release_pulse;
      n_vec++;
      if (dut_v !== mvec()) begin
        n_err++;
        $display("FAIL b2b_vec cyc%0d got %b exp %b", i, dut_v, mvec());
      end
    end
    n_vec++;
    if (np != 3 || nr != 3) begin
      n_err++;
      $display("FAIL b2b_counts got p%0d r%0d exp p3 r3", np, nr);
    end
  endtask

  task automatic test_reset_mid_hold();
    for (int i = 0; i < 3; i++) step(1, 0);
    for (int i = 0; i < 12; i++) step(1, 1);
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (dut_v !== '0) begin
      n_err++;
      $display("FAIL midrst_async got %b exp 0", dut_v);
    end
    mreset();
    step(1, 1);
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step(1, 0);
      n_vec++;
      if (dut_v !== mvec() || press_pulse !== (i == 3)) begin
        n_err++;
        $display("FAIL midrst_vec cyc%0d got %b exp %b", i, dut_v, mvec());
      end
    end
    for (int i = 0; i < 4; i++) step(0, 0);
  endtask

  task automatic test_random();
    bit lvl;
    int len, dens;
    lvl = 0;
    for (int ph = 0; ph < 120; ph++) begin
      lvl  = ~lvl;
      len  = $urandom_range(1, lvl ? 40 : 6);
      dens = $urandom_range(1, 4);
      for (int i = 0; i < len; i++) begin
        step(lvl, ($urandom_range(1, 4) <= dens));
        n_vec++;
        if (dut_v !== mvec()) begin
          n_err++;
          $display("FAIL rand_vec ph%0d cyc%0d got %b exp %b",
                   ph, i, dut_v, mvec());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_short_press();
    test_long_press();
    test_collision();
    test_saturation();
    test_back_to_back();
    test_reset_mid_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/btn_event_gen.md
Name: btn_event_gen

Overview:
- Consumer-side companion to the push-button debouncer.
- Takes the debounced button level and turns it into single-cycle events on the system clock: press, release, long-press and optional auto-repeat.
- Sits between the debouncer output and control logic (counters, LED shift loaders) that need one strobe per user action.
- Includes a 2-flop input synchroniser, because the debouncer runs in the slow 1 ms domain.

Parameters:
- LONG_MS, 1000, hold time in ms ticks before long_pulse fires; legal range 2..2^CNT_W-1.
- REPEAT_MS, 200, interval in ms ticks between repeat_pulse strobes after long-press; legal range 1..2^CNT_W-1.
- CNT_W, 16, width of the hold-time counter and hold_ms output.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- tick_1ms  in  1  single-clk-cycle strobe, once per ms, synchronous to clk.
- btn_level  in  1  debounced button level (1 = pressed); asynchronous to clk.
- press_pulse  out  1  one-cycle strobe on press.
- release_pulse  out  1  one-cycle strobe on release.
- long_pulse  out  1  one-cycle strobe when the hold reaches LONG_MS.
- repeat_pulse  out  1  one-cycle strobe every REPEAT_MS while in long hold.
- held  out  1  registered synchronised level.
- hold_ms  out  CNT_W  ms elapsed since press; saturates at all-ones; 0 when released.

Behaviour:
- Reset (async, rst=1): sync flops=0, state=IDLE, all pulses=0, held=0, hold_ms=0, repeat counter=0. Outputs clear immediately, without waiting for a clock edge.
- Synchroniser: btn_level passes through s1→s2 flops; held=s2. Edge detection compares s2 with its previous value.
- Latency: press_pulse and release_pulse assert 3 clk cycles after the btn_level transition (2 sync + 1 output register).
- All outputs are registered. Pulses are exactly one clk cycle wide.
- State IDLE:
  - s2 rising → PRESSED, press_pulse=1, hold_ms=0.
- State PRESSED:
  - On tick_1ms, hold_ms increments.
  - When the increment makes hold_ms==LONG_MS → LONG_HELD, long_pulse=1 in the same cycle, repeat counter=0.
  - s2 falling → IDLE, release_pulse=1, hold_ms=0.
- State LONG_HELD:
  - hold_ms keeps incrementing on ticks and saturates at 2^CNT_W-1; it never wraps.
  - Repeat counter increments on each tick. On reaching REPEAT_MS: repeat_pulse=1, counter←0.
  - s2 falling → IDLE, release_pulse=1, hold_ms=0, counter=0.
- Simultaneous events:
  - Falling edge and tick_1ms in the same cycle: release wins. No long_pulse or repeat_pulse; hold_ms→0.
  - Tick that completes LONG_MS: only long_pulse fires. First repeat_pulse comes REPEAT_MS ticks later.
- tick_1ms held high for multiple cycles: each high cycle counts as a tick. The driver must guarantee single-cycle strobes.
- Release and re-press with s2 low for ≥1 cycle: produces release_pulse then press_pulse, each on its own cycle. No merging.
- Reset mid-hold: everything clears. If the button is still pressed after rst drops, press_pulse fires 3 cycles later, since s2 rises from reset value 0.
- A press shorter than LONG_MS produces press_pulse and release_pulse only.

Optional Feature:
- Macro: BTN_AUTO_REPEAT_EN.
- Defined: the repeat counter and repeat_pulse behave as described above.
- Undefined:
  - Repeat counter is not built.
  - repeat_pulse is tied to 0.
  - LONG_HELD still exists; it only saturates hold_ms and waits for release.

Test Plan:
- Reset: assert rst mid-cycle with btn_level=1 → all outputs 0 immediately. After release of rst: press_pulse=1 exactly 3 clk later, one cycle wide.
- Short press: btn high for 50 ticks (LONG_MS=1000) → one press_pulse, hold_ms reaches 50, one release_pulse, no long_pulse, hold_ms=0 after release.
- Long press: LONG_MS=10, REPEAT_MS=3, macro defined, hold 20 ticks:
  - long_pulse on tick 10.
  - repeat_pulse on ticks 13, 16, 19.
  - release_pulse on release.
- Same long press, macro undefined → long_pulse on tick 10, repeat_pulse never asserts.
- Tick/release collision: drive the falling edge so s2 falls in the same cycle as the tick that would reach LONG_MS → release_pulse=1, long_pulse=0, hold_ms=0.
- Saturation: CNT_W=4, LONG_MS=5, hold 30 ticks → hold_ms stops at 15 and never wraps; release clears it to 0.
